// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU memory ports and the memory responder.
interface mem_responder_if #(
    parameter int WORD_W = 16
);
    logic              i_mem_read;
    logic [15:0]       i_address;
    logic [WORD_W-1:0] i_data;
    logic              i_ready;

    logic              d_mem_read;
    logic              d_mem_write;
    logic [15:0]       d_address;
    logic [WORD_W-1:0] d_data_in;
    logic [WORD_W-1:0] d_data;
    logic              d_ready;

    logic              busy;

    modport master (
        output i_mem_read, i_address, d_mem_read, d_mem_write, d_address, d_data_in,
        input  i_data, i_ready, d_data, d_ready, busy
    );

    modport slave (
        input  i_mem_read, i_address, d_mem_read, d_mem_write, d_address, d_data_in,
        output i_data, i_ready, d_data, d_ready, busy
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency memory responder serving an instruction port and a data port
// from one shared word array. The data port wins arbitration; each request
// completes with a single-cycle ready pulse LATENCY cycles after acceptance.
module mem_responder #(
    parameter int WORD_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input logic            clk,
    input logic            reset,
    mem_responder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t state;
    state_t state_next;

    logic [3:0]        count;

    logic              req_port_d;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;

    logic              acc_valid;
    logic              acc_port_d;
    logic              acc_write;
    logic [ADDR_W-1:0] acc_addr;

    logic              resp_port_d;
    logic              resp_write;
    logic [ADDR_W-1:0] resp_addr;
    logic [WORD_W-1:0] resp_wdata;
    logic              enter_resp;

    logic [WORD_W-1:0] i_data_r;
    logic [WORD_W-1:0] d_data_r;
    logic              i_ready_r;
    logic              d_ready_r;

    logic [WORD_W-1:0] mem [2**ADDR_W];

    // Upper address bits are deliberately ignored so addresses wrap onto the array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.i_address[15:ADDR_W], bus.d_address[15:ADDR_W]};

    // Arbitrate incoming requests: any data request beats the instruction fetch,
    // and a simultaneous read+write on the data port is treated as a write.
    always_comb begin
        acc_valid  = 1'b0;
        acc_port_d = 1'b0;
        acc_write  = 1'b0;
        acc_addr   = '0;
        if (bus.d_mem_read || bus.d_mem_write) begin
            acc_valid  = 1'b1;
            acc_port_d = 1'b1;
            acc_write  = bus.d_mem_write;
            acc_addr   = bus.d_address[ADDR_W-1:0];
        end else if (bus.i_mem_read) begin
            acc_valid  = 1'b1;
            acc_addr   = bus.i_address[ADDR_W-1:0];
        end
    end

    // Next-state logic; with single-cycle latency the WAIT state is skipped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (acc_valid) begin
                    if (LATENCY == 1) state_next = RESP;
                    else              state_next = WAIT;
                end
            end
            WAIT: begin
                if (count <= 4'd1) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Select the transaction that completes on the edge entering RESP: the live
    // request when coming straight from IDLE, otherwise the latched one.
    always_comb begin
        enter_resp = (state_next == RESP);
        if (state == IDLE) begin
            resp_port_d = acc_port_d;
            resp_write  = acc_write;
            resp_addr   = acc_addr;
            resp_wdata  = bus.d_data_in;
        end else begin
            resp_port_d = req_port_d;
            resp_write  = req_write;
            resp_addr   = req_addr;
            resp_wdata  = req_wdata;
        end
    end

    // State register, request latch, latency counter and registered responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 4'd0;
            req_port_d <= 1'b0;
            req_write  <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            i_ready_r  <= 1'b0;
            d_ready_r  <= 1'b0;
            i_data_r   <= '0;
            d_data_r   <= '0;
        end else begin
            state     <= state_next;
            i_ready_r <= 1'b0;
            d_ready_r <= 1'b0;
            if (state == IDLE && acc_valid) begin
                req_port_d <= acc_port_d;
                req_write  <= acc_write;
                req_addr   <= acc_addr;
                req_wdata  <= bus.d_data_in;
                count      <= LAT_M1;
            end else if (state == WAIT) begin
                count <= count - 4'd1;
            end
            if (enter_resp) begin
                if (resp_port_d) begin
                    d_ready_r <= 1'b1;
                    d_data_r  <= resp_write ? '0 : mem[resp_addr];
                end else begin
                    i_ready_r <= 1'b1;
                    i_data_r  <= mem[resp_addr];
                end
            end
        end
    end

    // Array write commits only on the edge entering RESP, so a reset that
    // aborts the transaction earlier keeps the old contents.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && resp_write) begin
            mem[resp_addr] <= resp_wdata;
        end
    end

    assign bus.i_data  = i_data_r;
    assign bus.d_data  = d_data_r;
    assign bus.i_ready = i_ready_r;
    assign bus.d_ready = d_ready_r;
    assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with LATENCY=2 and one with
// LATENCY=1. Inputs change and outputs are checked on the falling clock edge.
module tb_mem_responder;

    logic clk;
    logic reset;

    int assertCount;
    int failCount;

    mem_responder_if #(.WORD_W(16)) bus0 ();
    mem_responder_if #(.WORD_W(16)) bus1 ();

    mem_responder #(.WORD_W(16), .ADDR_W(8), .LATENCY(2)) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    mem_responder #(.WORD_W(16), .ADDR_W(8), .LATENCY(1)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one data-port request on the LATENCY=2 instance and check the full
    // accept / wait / respond / idle sequence.
    task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                                 input logic [15:0] addr, input logic [15:0] wdata,
                                 input logic [15:0] expData);
        bus0.d_mem_read  = rd;
        bus0.d_mem_write = wr;
        bus0.d_address   = addr;
        bus0.d_data_in   = wdata;
        tick();
        checkOutput({tag, " busy t+1"}, 32'(bus0.busy), 32'd1);
        checkOutput({tag, " d_ready t+1"}, 32'(bus0.d_ready), 32'd0);
        tick();
        checkOutput({tag, " d_ready t+2"}, 32'(bus0.d_ready), 32'd1);
        checkOutput({tag, " i_ready t+2"}, 32'(bus0.i_ready), 32'd0);
        checkOutput({tag, " d_data t+2"}, 32'(bus0.d_data), 32'(expData));
        bus0.d_mem_read  = 1'b0;
        bus0.d_mem_write = 1'b0;
        tick();
        checkOutput({tag, " d_ready t+3"}, 32'(bus0.d_ready), 32'd0);
        checkOutput({tag, " busy t+3"}, 32'(bus0.busy), 32'd0);
    endtask

    // Single-cycle-latency data write on the LATENCY=1 instance.
    task automatic u1Write(input logic [15:0] addr, input logic [15:0] wdata);
        bus1.d_mem_write = 1'b1;
        bus1.d_address   = addr;
        bus1.d_data_in   = wdata;
        tick();
        checkOutput("u1 write d_ready", 32'(bus1.d_ready), 32'd1);
        bus1.d_mem_write = 1'b0;
        tick();
    endtask

    // Directed test sequence.
    initial begin
        assertCount = 0;
        failCount   = 0;
        reset = 1'b1;
        bus0.i_mem_read = 1'b0; bus0.i_address = '0;
        bus0.d_mem_read = 1'b0; bus0.d_mem_write = 1'b0;
        bus0.d_address  = '0;   bus0.d_data_in = '0;
        bus1.i_mem_read = 1'b0; bus1.i_address = '0;
        bus1.d_mem_read = 1'b0; bus1.d_mem_write = 1'b0;
        bus1.d_address  = '0;   bus1.d_data_in = '0;
        repeat (3) tick();

        $display("[TB] reset state");
        checkOutput("reset busy", 32'(bus0.busy), 32'd0);
        checkOutput("reset i_ready", 32'(bus0.i_ready), 32'd0);
        checkOutput("reset d_ready", 32'(bus0.d_ready), 32'd0);
        checkOutput("reset i_data", 32'(bus0.i_data), 32'd0);
        checkOutput("reset d_data", 32'(bus0.d_data), 32'd0);
        reset = 1'b0;
        tick();

        $display("[TB] write then read back");
        applyStimulus("wr 0010", 1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000);
        applyStimulus("rd 0010", 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);

        $display("[TB] data priority over instruction fetch");
        applyStimulus("wr 0003", 1'b0, 1'b1, 16'h0003, 16'h0333, 16'h0000);
        applyStimulus("wr 0004", 1'b0, 1'b1, 16'h0004, 16'h0444, 16'h0000);
        bus0.i_mem_read = 1'b1;
        bus0.i_address  = 16'h0003;
        bus0.d_mem_read = 1'b1;
        bus0.d_address  = 16'h0004;
        tick();
        checkOutput("prio busy t+1", 32'(bus0.busy), 32'd1);
        tick();
        checkOutput("prio d_ready t+2", 32'(bus0.d_ready), 32'd1);
        checkOutput("prio i_ready t+2", 32'(bus0.i_ready), 32'd0);
        checkOutput("prio d_data t+2", 32'(bus0.d_data), 32'h0444);
        bus0.d_mem_read = 1'b0;
        tick();
        checkOutput("prio busy t+3", 32'(bus0.busy), 32'd0);
        checkOutput("prio i_ready t+3", 32'(bus0.i_ready), 32'd0);
        tick();
        checkOutput("prio i_ready t+4", 32'(bus0.i_ready), 32'd0);
        tick();
        checkOutput("prio i_ready t+5", 32'(bus0.i_ready), 32'd1);
        checkOutput("prio i_data t+5", 32'(bus0.i_data), 32'h0333);
        checkOutput("prio d_ready t+5", 32'(bus0.d_ready), 32'd0);
        checkOutput("prio d_data hold", 32'(bus0.d_data), 32'h0444);
        bus0.i_mem_read = 1'b0;
        tick();
        checkOutput("prio i_ready t+6", 32'(bus0.i_ready), 32'd0);

        $display("[TB] address wrap");
        applyStimulus("wr 0105", 1'b0, 1'b1, 16'h0105, 16'h1234, 16'h0000);
        applyStimulus("rd 0005", 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h1234);

        $display("[TB] reset aborts pending write");
        applyStimulus("wr 0020", 1'b0, 1'b1, 16'h0020, 16'h1111, 16'h0000);
        bus0.d_mem_write = 1'b1;
        bus0.d_address   = 16'h0020;
        bus0.d_data_in   = 16'h2222;
        tick();
        checkOutput("abort busy wait", 32'(bus0.busy), 32'd1);
        reset = 1'b1;
        bus0.d_mem_write = 1'b0;
        tick();
        checkOutput("abort busy", 32'(bus0.busy), 32'd0);
        checkOutput("abort d_ready", 32'(bus0.d_ready), 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("abort d_ready later", 32'(bus0.d_ready), 32'd0);
        applyStimulus("rd 0020", 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1111);

        $display("[TB] read+write collision");
        applyStimulus("rw 0030", 1'b1, 1'b1, 16'h0030, 16'h00AA, 16'h0000);
        applyStimulus("rd 0030", 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h00AA);

        $display("[TB] single-cycle latency back-to-back fetches");
        u1Write(16'h0000, 16'h5A5A);
        u1Write(16'h0001, 16'hA5A5);
        bus1.i_mem_read = 1'b1;
        bus1.i_address  = 16'h0000;
        tick();
        checkOutput("lat1 i_ready t+1", 32'(bus1.i_ready), 32'd1);
        checkOutput("lat1 i_data t+1", 32'(bus1.i_data), 32'h5A5A);
        bus1.i_address = 16'h0001;
        tick();
        checkOutput("lat1 i_ready t+2", 32'(bus1.i_ready), 32'd0);
        checkOutput("lat1 i_data hold", 32'(bus1.i_data), 32'h5A5A);
        tick();
        checkOutput("lat1 i_ready t+3", 32'(bus1.i_ready), 32'd1);
        checkOutput("lat1 i_data t+3", 32'(bus1.i_data), 32'hA5A5);
        bus1.i_mem_read = 1'b0;
        tick();
        checkOutput("lat1 i_ready t+4", 32'(bus1.i_ready), 32'd0);
        checkOutput("lat1 busy t+4", 32'(bus1.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the CPU's instruction and data memory request signals. It serves instruction-fetch reads and data reads/writes from one internal word array with a fixed, parameterised latency, and returns a one-cycle ready pulse per request. It sits between the datapath's memory request outputs and the backing store, and replaces zero-latency memory in simulation.

Parameters:
WORD_W, 16, data word width in bits.
ADDR_W, 8, index bits used; array depth is 2^ADDR_W words.
LATENCY, 2, cycles from request acceptance to ready pulse; legal range is 1..15.

Ports:
clk  in  1  clock; all logic rises on posedge.
reset  in  1  synchronous, active-high reset.
i_mem_read  in  1  instruction read request; level, held until i_ready.
i_address  in  16  instruction word address.
i_data  out  WORD_W  instruction read data; valid while i_ready=1.
i_ready  out  1  one-cycle completion pulse for the instruction port.
d_mem_read  in  1  data read request; level, held until d_ready.
d_mem_write  in  1  data write request; level, held until d_ready.
d_address  in  16  data word address.
d_data_in  in  WORD_W  write data.
d_data  out  WORD_W  data read result; valid while d_ready=1.
d_ready  out  1  one-cycle completion pulse for the data port.
busy  out  1  high whenever the state is not IDLE.

Behaviour:
- States:
  - IDLE: accepts new requests.
  - WAIT: counts down the latency; only entered when LATENCY>1.
  - RESP: ready pulse cycle.
- Reset (synchronous, checked every edge, overrides everything): state=IDLE, counter=0, i_ready=0, d_ready=0, i_data=0, d_data=0, busy=0. Array contents are not cleared.
- Acceptance happens at the posedge ending an IDLE cycle t in which a request is high. The responder latches the port, the kind (read or write), address[ADDR_W-1:0] and d_data_in.
- Arbitration: the data port has fixed priority. If d_mem_read or d_mem_write is high, the data request is accepted. Otherwise i_mem_read is accepted. Otherwise the block stays in IDLE.
- d_mem_read and d_mem_write both high is illegal. The write takes precedence, and a write response drives d_data=0.
- State sequence after acceptance:
  - LATENCY=1: IDLE -> RESP.
  - LATENCY>1: IDLE -> WAIT for LATENCY-1 cycles -> RESP.
  - RESP is cycle t+LATENCY. RESP always returns to IDLE.
- Counter: loaded with LATENCY-1 on acceptance, decremented in WAIT, WAIT exits when it reaches 1. Width is 4 bits.
- Write: the array word is updated at the edge entering RESP, never earlier. d_ready=1 in RESP.
- Read: the array word is sampled at the edge entering RESP and presented on i_data or d_data during RESP, together with the matching ready.
- Only the served port's ready and data change. i_data and d_data hold their last values until that port's next response.
- Ready pulses are exactly one cycle wide and never high together.
- Requests are not sampled in RESP. The requester drops its request at the edge after ready, so a new request is accepted at the earliest in the IDLE cycle t+LATENCY+1. Throughput is one request per LATENCY+1 cycles.
- Address wrap: upper address bits [15:ADDR_W] are ignored.
- Reset during WAIT or RESP aborts the pending request:
  - no ready pulse is issued;
  - an aborted write never reaches the array;
  - the next cycle is IDLE.
- Request deasserted during WAIT (protocol violation): the transaction still completes and ready still pulses.
- Starvation of the instruction port under continuous data traffic is allowed; the CPU never issues such traffic.

Test Plan:
1. LATENCY=2, reset, then d write 0x0010 with data 0xBEEF accepted at t -> busy high in t+1..t+2, d_ready high only in t+2. A following d read of 0x0010 -> d_data=0xBEEF with d_ready, i_ready stays 0.
2. i_mem_read at 0x0003 and d_mem_read at 0x0004 raised in the same IDLE cycle -> d_ready at t+2. The instruction request is accepted at t+3, giving i_ready at t+5 with the word at 0x0003.
3. ADDR_W=8: write 0x1234 to 0x0105, then read 0x0005 -> d_data=0x1234.
4. Word 0x0020 holds 0x1111. Start a write of 0x2222 to it and assert reset in the WAIT cycle -> no d_ready, busy=0 next cycle. A later read returns 0x1111.
5. d_mem_read and d_mem_write both high with data 0x00AA to 0x0030 -> d_ready with d_data=0. A read of 0x0030 returns 0x00AA.
6. LATENCY=1, back-to-back i reads of 0x0000 and 0x0001 -> i_ready pulses two cycles apart, carrying the correct words.
